// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory and decode-side signal bundle of the fetch unit
interface fetch_unit_if #(
  parameter int DATA_W = 32
);
  logic              imem_req_valid_o;
  logic              imem_req_ready_i;
  logic [DATA_W-1:0] imem_req_addr_o;
  logic              imem_rsp_valid_i;
  logic [DATA_W-1:0] imem_rsp_data_i;
  logic              imem_rsp_err_i;
  logic              hazard_stall_i;
  logic              instr_valid_o;
  logic [DATA_W-1:0] instr_o;
  logic [DATA_W-1:0] instr_pc_o;
  logic              instr_err_o;

  modport master (
    output imem_req_valid_o, imem_req_addr_o,
    input  imem_req_ready_i,
    input  imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i,
    input  hazard_stall_i,
    output instr_valid_o, instr_o, instr_pc_o, instr_err_o
  );

  modport slave (
    input  imem_req_valid_o, imem_req_addr_o,
    output imem_req_ready_i,
    output imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i,
    output hazard_stall_i,
    input  instr_valid_o, instr_o, instr_pc_o, instr_err_o
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with credit-limited requests and in-order buffer
module fetch_unit #(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              redirect_i,
  input  logic [DATA_W-1:0] redirect_pc_i,
  fetch_unit_if.master      bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [DATA_W-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
    logic              err;
  } entry_t;

  entry_t            fifo_q [FIFO_DEPTH];
  entry_t            fifo_d [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic [DATA_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_W-1:0] rsp_pc_q, rsp_pc_d;

  logic [CW:0]       inflight;
  logic [CW:0]       flush_total;
  logic [CW:0]       flush_pending;
  logic              req_fire, rsp_keep, rsp_drop, pop;
  logic [DATA_W-1:0] redirect_pc_aligned;
  logic              unused_pc_bits;

  assign unused_pc_bits      = ^redirect_pc_i[1:0];
  assign redirect_pc_aligned = {redirect_pc_i[DATA_W-1:2], 2'b00};

  assign inflight             = {1'b0, outstanding_q} + {1'b0, count_q};
  assign bus.imem_req_valid_o = !rst_i && !redirect_i && (inflight < (CW+1)'(FIFO_DEPTH));
  assign bus.imem_req_addr_o  = fetch_pc_q;

  assign req_fire = bus.imem_req_valid_o && bus.imem_req_ready_i;
  assign rsp_drop = bus.imem_rsp_valid_i && (discard_q != '0);
  assign rsp_keep = bus.imem_rsp_valid_i && (discard_q == '0) && (outstanding_q != '0);
  assign pop      = (count_q != '0) && !bus.hazard_stall_i;

  // A response arriving in the redirect cycle retires one pending fetch rather than being counted.
  assign flush_total   = {1'b0, discard_q} + {1'b0, outstanding_q};
  assign flush_pending = (bus.imem_rsp_valid_i && flush_total != '0) ?
                         flush_total - (CW+1)'(1) : flush_total;

  assign bus.instr_valid_o = (count_q != '0);
  assign bus.instr_o       = bus.instr_valid_o ? fifo_q[rd_ptr_q].data : '0;
  assign bus.instr_pc_o    = bus.instr_valid_o ? fifo_q[rd_ptr_q].pc : '0;
  assign bus.instr_err_o   = bus.instr_valid_o && fifo_q[rd_ptr_q].err;

  always_comb begin
    fifo_d        = fifo_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    if (redirect_i) begin
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      count_d       = '0;
      outstanding_d = '0;
      discard_d     = flush_pending[CW-1:0];
      fetch_pc_d    = redirect_pc_aligned;
      rsp_pc_d      = redirect_pc_aligned;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + DATA_W'(4);
      end
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_keep);
      if (rsp_drop) begin
        discard_d = discard_q - CW'(1);
      end
      if (rsp_keep) begin
        fifo_d[wr_ptr_q] = '{data: bus.imem_rsp_err_i ? NOP : bus.imem_rsp_data_i,
                             pc:   rsp_pc_q,
                             err:  bus.imem_rsp_err_i};
        wr_ptr_d = wr_ptr_q + PW'(1);
        rsp_pc_d = rsp_pc_q + DATA_W'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(rsp_keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
    end else begin
      fifo_q        <= fifo_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
    end
  end

  a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.imem_rsp_valid_i |-> (outstanding_q != '0 || discard_q != '0));
  a_discard_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    redirect_i |-> (flush_pending <= (CW+1)'(FIFO_DEPTH)));
  a_credit_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    inflight <= (CW+1)'(FIFO_DEPTH));
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  always #5 clk = ~clk;

  fetch_unit_if #(.DATA_W(32)) bus ();

  fetch_unit #(.DATA_W(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .bus          (bus)
  );

  int          checks = 0;
  int          errors = 0;
  bit          auto_rsp = 1'b1;
  int          release_n = 0;
  int          hs_count = 0;
  logic [31:0] fault_addr = 32'h1;
  logic [31:0] pend_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'hA500_0000);
  endfunction

  // One clock: sample the request handshake mid-cycle, then drive the next-cycle response.
  task automatic cycle();
    bit          hs;
    logic [31:0] a;
    logic [31:0] r;
    #1;
    hs = bus.imem_req_valid_o && bus.imem_req_ready_i;
    a  = bus.imem_req_addr_o;
    if (hs) hs_count++;
    @(posedge clk);
    #1;
    if (hs) pend_q.push_back(a);
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_err_i   = 1'b0;
    if ((auto_rsp || release_n > 0) && pend_q.size() > 0) begin
      r = pend_q.pop_front();
      bus.imem_rsp_valid_i = 1'b1;
      bus.imem_rsp_data_i  = mem_word(r);
      bus.imem_rsp_err_i   = (r == fault_addr);
      if (!auto_rsp) release_n--;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    bus.hazard_stall_i = 1'b0;
    pend_q.delete();
    release_n = 0;
    cycle();
    rst = 1'b0;
    hs_count = 0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bus.imem_req_ready_i = 1'b0;
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_data_i  = '0;
    bus.imem_rsp_err_i   = 1'b0;
    bus.hazard_stall_i   = 1'b0;

    cycle();
    cycle();
    check("rst_instr_valid", bus.instr_valid_o, 0);
    check("rst_instr", bus.instr_o, 0);
    check("rst_instr_pc", bus.instr_pc_o, 0);
    check("rst_instr_err", bus.instr_err_o, 0);
    check("rst_req_valid", bus.imem_req_valid_o, 0);

    // reset to first fetch
    rst = 1'b0;
    bus.imem_req_ready_i = 1'b1;
    #1;
    check("t1_req_valid", bus.imem_req_valid_o, 1);
    check("t1_addr0", bus.imem_req_addr_o, 32'h0);
    cycle();
    check("t1_addr4", bus.imem_req_addr_o, 32'h4);
    check("t1_not_yet_valid", bus.instr_valid_o, 0);
    cycle();
    check("t1_valid", bus.instr_valid_o, 1);
    check("t1_instr", bus.instr_o, 32'h0050_0093);
    check("t1_pc", bus.instr_pc_o, 32'h0);
    check("t1_err", bus.instr_err_o, 0);
    cycle();
    check("t1_pc4", bus.instr_pc_o, 32'h4);
    check("t1_instr4", bus.instr_o, 32'hA500_0004);
    check("t1_req_addr8", bus.imem_req_addr_o, 32'h8);

    // credit limit with a silent memory
    do_reset();
    auto_rsp = 1'b0;
    cycle();
    cycle();
    for (int i = 0; i < 6; i++) begin
      check("t2_no_req", bus.imem_req_valid_o, 0);
      cycle();
    end
    check("t2_hs_count", hs_count, 2);
    check("t2_addr_hold", bus.imem_req_addr_o, 32'h8);
    release_n = 2;
    cycle();
    cycle();
    check("t2_pc0", bus.instr_pc_o, 32'h0);
    check("t2_instr0", bus.instr_o, 32'h0050_0093);
    cycle();
    check("t2_pc4", bus.instr_pc_o, 32'h4);
    check("t2_resume_valid", bus.imem_req_valid_o, 1);
    check("t2_resume_addr", bus.imem_req_addr_o, 32'h8);

    // stall hold with full buffer
    do_reset();
    auto_rsp = 1'b1;
    bus.hazard_stall_i = 1'b1;
    cycle();
    cycle();
    check("t3_head_valid", bus.instr_valid_o, 1);
    cycle();
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_pc", bus.instr_pc_o, 32'h0);
      check("t3_hold_instr", bus.instr_o, 32'h0050_0093);
      check("t3_no_req", bus.imem_req_valid_o, 0);
      cycle();
    end
    check("t3_hs_count", hs_count, 2);
    bus.hazard_stall_i = 1'b0;
    check("t3_pop_pc0", bus.instr_pc_o, 32'h0);
    cycle();
    check("t3_pop_pc4", bus.instr_pc_o, 32'h4);
    check("t3_pop_instr4", bus.instr_o, 32'hA500_0004);
    cycle();
    check("t3_drained", bus.instr_valid_o, 0);

    // redirect with two fetches in flight, one response coincident
    do_reset();
    auto_rsp = 1'b0;
    cycle();
    cycle();
    release_n = 1;
    cycle();
    redirect = 1'b1;
    redirect_pc = 32'h0000_1003;
    #1;
    check("t4_req_withdrawn", bus.imem_req_valid_o, 0);
    cycle();
    redirect = 1'b0;
    #1;
    check("t4_flushed", bus.instr_valid_o, 0);
    check("t4_req_valid", bus.imem_req_valid_o, 1);
    check("t4_req_addr", bus.imem_req_addr_o, 32'h0000_1000);
    release_n = 3;
    cycle();
    check("t4_drop_a", bus.instr_valid_o, 0);
    cycle();
    check("t4_drop_b", bus.instr_valid_o, 0);
    cycle();
    check("t4_valid", bus.instr_valid_o, 1);
    check("t4_pc", bus.instr_pc_o, 32'h0000_1000);
    check("t4_instr", bus.instr_o, 32'hA500_1000);
    cycle();
    check("t4_pc_next", bus.instr_pc_o, 32'h0000_1004);

    // access fault
    do_reset();
    auto_rsp = 1'b1;
    fault_addr = 32'h8;
    repeat (5) cycle();
    check("t5_valid", bus.instr_valid_o, 1);
    check("t5_pc", bus.instr_pc_o, 32'h8);
    check("t5_nop", bus.instr_o, 32'h0000_0013);
    check("t5_err", bus.instr_err_o, 1);
    cycle();
    check("t5_next_pc", bus.instr_pc_o, 32'hC);
    check("t5_next_err", bus.instr_err_o, 0);
    check("t5_next_instr", bus.instr_o, 32'hA500_000C);
    fault_addr = 32'h1;

    // address wrap
    do_reset();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    #1;
    check("t6_req_withdrawn", bus.imem_req_valid_o, 0);
    cycle();
    redirect = 1'b0;
    #1;
    check("t6_addr_top", bus.imem_req_addr_o, 32'hFFFF_FFFC);
    check("t6_req_valid", bus.imem_req_valid_o, 1);
    cycle();
    check("t6_addr_wrap", bus.imem_req_addr_o, 32'h0);
    cycle();
    check("t6_pc_top", bus.instr_pc_o, 32'hFFFF_FFFC);
    check("t6_instr_top", bus.instr_o, 32'h5AFF_FFFC);
    cycle();
    check("t6_pc_wrap", bus.instr_pc_o, 32'h0);
    check("t6_instr_wrap", bus.instr_o, 32'h0050_0093);

    // back-to-back redirects accumulate discards
    do_reset();
    auto_rsp = 1'b0;
    cycle();
    cycle();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    cycle();
    redirect_pc = 32'h0000_0300;
    cycle();
    redirect = 1'b0;
    #1;
    check("t7_addr", bus.imem_req_addr_o, 32'h0000_0300);
    cycle();
    release_n = 4;
    cycle();
    cycle();
    cycle();
    check("t7_dropped", bus.instr_valid_o, 0);
    cycle();
    check("t7_valid", bus.instr_valid_o, 1);
    check("t7_pc", bus.instr_pc_o, 32'h0000_0300);
    check("t7_instr", bus.instr_o, 32'hA500_0300);
    cycle();
    check("t7_pc_next", bus.instr_pc_o, 32'h0000_0304);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch front end that produces the `instr` stream consumed by the decode stage.
- Issues word fetch requests to instruction memory.
- Buffers in-order responses in a small FIFO.
- Presents one instruction per cycle with its PC, honouring the decode stall.
- Handles control-flow redirects by flushing buffered and in-flight fetches, then restarting at the new PC.

Parameters:
- DATA_W, 32, instruction/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2; also the cap on outstanding requests plus buffered entries.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- redirect_i  in  1  flush and restart fetch (branch/jump/trap).
- redirect_pc_i  in  DATA_W  restart address; bits [1:0] ignored (treated as 0).
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  memory accepts request.
- imem_req_addr_o  out  DATA_W  fetch address, word aligned.
- imem_rsp_valid_i  in  1  response valid; in request order; no backpressure.
- imem_rsp_data_i  in  DATA_W  fetched word.
- imem_rsp_err_i  in  1  access fault for this response.
- hazard_stall_i  in  1  decode cannot accept this cycle.
- instr_valid_o  out  1  instr_o/instr_pc_o valid.
- instr_o  out  DATA_W  instruction to decode.
- instr_pc_o  out  DATA_W  PC of instr_o.
- instr_err_o  out  1  fetch fault for this instruction.

Behaviour:
- **Reset** (rst_i high at a clock edge):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0.
  - Outputs in the cycle after reset: instr_valid_o=0, instr_o=0, instr_pc_o=0, instr_err_o=0, imem_req_valid_o=0.
  - Reset mid-operation discards everything; late responses from pre-reset requests are the memory's responsibility (memory is reset together with this block).
- **Credit:** imem_req_valid_o = !rst_i && !redirect_i && (outstanding + fifo_count < FIFO_DEPTH).
- **Request issue:**
  - imem_req_addr_o = fetch_pc (registered).
  - Request handshake = valid && ready → outstanding+1, fetch_pc+=4; wraps modulo 2^DATA_W (0xFFFF_FFFC → 0x0).
  - Address stays stable while valid && !ready, except when withdrawn by redirect.
  - Memory must tolerate withdrawal on redirect.
- **Response accept:**
  - If discard>0: response is dropped and discard−1.
  - Otherwise outstanding−1 and the FIFO is written with {data, pc, err}.
  - Entry PC comes from a separate rsp_pc register advanced by 4 per kept response, set on redirect/reset.
- **Fault responses:** the stored data is forced to 32'h0000_0013 (NOP) and err=1.
- **Output:**
  - FIFO head is registered; no bypass. A response written at edge N is visible at instr_valid_o in cycle N+1.
  - Consume = instr_valid_o && !hazard_stall_i; pops head.
  - While stalled, instr_o/instr_pc_o/instr_err_o hold stable.
- **Simultaneous events:**
  - Push and pop in the same cycle are allowed when full; count unchanged.
  - Credit guarantees no FIFO overflow. A response with outstanding=0 and discard=0 is a protocol error: ignore it and flag it by assertion.
- **Redirect** (cycle t, priority over everything):
  - At edge t: FIFO cleared; discard = outstanding + (response arriving at t is dropped, not counted); outstanding=0.
  - fetch_pc = rsp_pc = {redirect_pc_i[DATA_W-1:2],2'b00}.
  - No request issues in cycle t.
  - instr_valid_o=0 in cycle t+1.
  - First new request is visible in cycle t+1.
  - Redirect with concurrent consume: flush wins.
  - Back-to-back redirects: last one wins; discard accumulates correctly.
- **Counter widths:** outstanding, discard and fifo_count are each $clog2(FIFO_DEPTH+1) bits.
  - discard never exceeds FIFO_DEPTH.
  - Saturation must not occur; guard it with an assertion.

Test Plan:
1. **Reset → first fetch:** rst_i 1→0, ready=1, 1-cycle memory returning 0x00500093 → req addr 0x0 then 0x4.
   - instr_valid_o first high 2 cycles after the first request handshake, with instr_o=0x00500093, instr_pc_o=0x0.
2. **Credit limit:** ready=1, memory never responds → exactly 2 request handshakes (0x0, 0x4), then imem_req_valid_o=0 indefinitely.
   - After 2 responses and 2 consumes, requests resume at 0x8.
3. **Stall hold:** FIFO full, hazard_stall_i=1 for 5 cycles → instr_o/instr_pc_o unchanged and no new request.
   - Releasing the stall pops one entry per cycle in PC order 0x0, 0x4.
4. **Redirect with in-flight fetches:** 2 outstanding, redirect_i with redirect_pc_i=0x0000_1003 → both late responses dropped.
   - Next request addr 0x0000_1000; first delivered instr_pc_o=0x1000.
   - Any response coincident with the redirect is dropped.
5. **Fault:** response with imem_rsp_err_i=1 at PC 0x8 → instr_o=0x00000013, instr_err_o=1, instr_pc_o=0x8.
   - The following instruction at 0xC has err=0.
6. **Wrap:** redirect to 0xFFFF_FFFC → request addresses 0xFFFF_FFFC then 0x0000_0000; delivered PCs match.
